// File: rtl/sram_row_ctrl.sv
// -----------------------------------------------------------------------------
// sram_row_ctrl
//   Initiator-side controller for the frame SRAM. Serialises three request
//   streams onto the single SRAM port, one operation at a time:
//     - indexed row-cache reads for the window buffer (highest priority),
//     - window-buffer result writes into the output array,
//     - SDRAM words ping-pong filled into two row-cache regions.
//   Every SRAM-facing output and every ack/valid pulse is registered.
//
// Ports
//   clk, n_rst                 clock, asynchronous active-low reset
//   sd_valid/sd_data/sd_ack    SDRAM buffer word stream into the row caches
//   row_full[1:0]              row r completely filled
//   row_release[1:0]           one-cycle pulse clears row_full[r]
//   rd_req/rd_row/rd_idx       window-buffer read request
//   rd_ack/rd_valid/rd_data    read accept pulse, result pulse, held result
//   wb_valid/wb_data/wb_ack    window-buffer result stream into output array
//   sram_*                     SRAM address, mode, data mux select, strobe,
//                              write data buses and read return
//   err                        sticky: SRAM read return not valid in CAPTURE
// -----------------------------------------------------------------------------
module sram_row_ctrl #(
  parameter int unsigned ROW_LEN   = 640,
  parameter int unsigned OUT_LEN   = 307200,
  parameter logic [25:0] ROW0_BASE = 26'd0,
  parameter logic [25:0] ROW1_BASE = 26'd4096,
  parameter logic [25:0] OUT_BASE  = 26'd8192
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sd_valid,
  input  logic [31:0] sd_data,
  output logic        sd_ack,
  output logic [1:0]  row_full,
  input  logic [1:0]  row_release,
  input  logic        rd_req,
  input  logic        rd_row,
  input  logic [12:0] rd_idx,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        wb_valid,
  input  logic [31:0] wb_data,
  output logic        wb_ack,
  output logic [25:0] sram_address,
  output logic        sram_mode,
  output logic        sram_addr_calc_mode,
  output logic        sram_enable,
  output logic [31:0] sram_sd_data,
  output logic [31:0] sram_wb_data,
  input  logic [31:0] sram_out_data,
  input  logic        sram_read_valid,
  output logic        err
);

  localparam int FILL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int OUT_W  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(ROW_LEN - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(OUT_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  state_t              state, state_nxt;
  logic [FILL_W-1:0]   fill_cnt, fill_cnt_nxt;
  logic [OUT_W-1:0]    out_cnt, out_cnt_nxt;
  logic                fill_row, fill_row_nxt;
  logic [1:0]          row_set;
  logic [1:0]          row_full_nxt;
  logic                err_nxt;
  logic [31:0]         rd_data_nxt;
  logic                rd_valid_nxt, rd_ack_nxt, wb_ack_nxt, sd_ack_nxt;
  logic [25:0]         sram_address_nxt;
  logic                sram_mode_nxt, sram_addr_calc_mode_nxt, sram_enable_nxt;
  logic [31:0]         sram_sd_data_nxt, sram_wb_data_nxt;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt               = state;
    fill_cnt_nxt            = fill_cnt;
    out_cnt_nxt             = out_cnt;
    fill_row_nxt            = fill_row;
    row_set                 = 2'b00;
    err_nxt                 = err;
    rd_data_nxt             = rd_data;
    rd_valid_nxt            = 1'b0;
    rd_ack_nxt              = 1'b0;
    wb_ack_nxt              = 1'b0;
    sd_ack_nxt              = 1'b0;
    sram_address_nxt        = sram_address;
    sram_mode_nxt           = sram_mode;
    sram_addr_calc_mode_nxt = sram_addr_calc_mode;
    sram_enable_nxt         = 1'b0;
    sram_sd_data_nxt        = sram_sd_data;
    sram_wb_data_nxt        = sram_wb_data;

    unique case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt        = READ;
          sram_enable_nxt  = 1'b1;
          sram_mode_nxt    = 1'b1;
          // Index is not range-checked against ROW_LEN; issued as computed.
          sram_address_nxt = (rd_row ? ROW1_BASE : ROW0_BASE) + 26'(rd_idx);
          rd_ack_nxt       = 1'b1;
        end else if (wb_valid) begin
          state_nxt               = WRITE;
          sram_enable_nxt         = 1'b1;
          sram_mode_nxt           = 1'b0;
          sram_addr_calc_mode_nxt = 1'b0;
          sram_wb_data_nxt        = wb_data;
          sram_address_nxt        = OUT_BASE + 26'(out_cnt);
          wb_ack_nxt              = 1'b1;
          out_cnt_nxt             = (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
        end else if (sd_valid && !row_full[fill_row]) begin
          // A full target row stalls the fill until it is released.
          state_nxt               = WRITE;
          sram_enable_nxt         = 1'b1;
          sram_mode_nxt           = 1'b0;
          sram_addr_calc_mode_nxt = 1'b1;
          sram_sd_data_nxt        = sd_data;
          sram_address_nxt        = (fill_row ? ROW1_BASE : ROW0_BASE) + 26'(fill_cnt);
          sd_ack_nxt              = 1'b1;
          if (fill_cnt == FILL_LAST) begin
            fill_cnt_nxt      = '0;
            row_set[fill_row] = 1'b1;
            fill_row_nxt      = ~fill_row;
          end else begin
            fill_cnt_nxt = fill_cnt + 1'b1;
          end
        end
      end
      READ: begin
        // SRAM samples the read on this edge; data returns next cycle.
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt    = IDLE;
        rd_data_nxt  = sram_out_data;
        rd_valid_nxt = 1'b1;
        if (!sram_read_valid) err_nxt = 1'b1;
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A fill completing on the same edge as a release of that row wins.
    row_full_nxt = (row_full & ~row_release) | row_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= IDLE;
      fill_cnt            <= '0;
      out_cnt             <= '0;
      fill_row            <= 1'b0;
      row_full            <= 2'b00;
      err                 <= 1'b0;
      rd_data             <= '0;
      rd_valid            <= 1'b0;
      rd_ack              <= 1'b0;
      wb_ack              <= 1'b0;
      sd_ack              <= 1'b0;
      sram_address        <= '0;
      sram_mode           <= 1'b0;
      sram_addr_calc_mode <= 1'b0;
      sram_enable         <= 1'b0;
      sram_sd_data        <= '0;
      sram_wb_data        <= '0;
    end else begin
      state               <= state_nxt;
      fill_cnt            <= fill_cnt_nxt;
      out_cnt             <= out_cnt_nxt;
      fill_row            <= fill_row_nxt;
      row_full            <= row_full_nxt;
      err                 <= err_nxt;
      rd_data             <= rd_data_nxt;
      rd_valid            <= rd_valid_nxt;
      rd_ack              <= rd_ack_nxt;
      wb_ack              <= wb_ack_nxt;
      sd_ack              <= sd_ack_nxt;
      sram_address        <= sram_address_nxt;
      sram_mode           <= sram_mode_nxt;
      sram_addr_calc_mode <= sram_addr_calc_mode_nxt;
      sram_enable         <= sram_enable_nxt;
      sram_sd_data        <= sram_sd_data_nxt;
      sram_wb_data        <= sram_wb_data_nxt;
    end
  end

endmodule

// File: tb/tb_sram_row_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_row_ctrl
//   Scoreboard bench for sram_row_ctrl with ROW_LEN=4 and OUT_LEN=3.
//   Source processes replay request queues with the ack handshake; the main
//   sequence pushes hand-computed SRAM operations and read results into
//   expectation queues; a monitor pops and compares whenever the DUT strobes
//   the SRAM or pulses rd_valid. A small SRAM model provides read data.
// -----------------------------------------------------------------------------
module tb_sram_row_ctrl;

  localparam int ROW_LEN = 4;
  localparam int OUT_LEN = 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        sd_valid, sd_ack;
  logic [31:0] sd_data;
  logic [1:0]  row_full, row_release;
  logic        rd_req, rd_row, rd_ack, rd_valid;
  logic [12:0] rd_idx;
  logic [31:0] rd_data;
  logic        wb_valid, wb_ack;
  logic [31:0] wb_data;
  logic [25:0] sram_address;
  logic        sram_mode, sram_addr_calc_mode, sram_enable;
  logic [31:0] sram_sd_data, sram_wb_data, sram_out_data;
  logic        sram_read_valid;
  logic        err;
  logic        srv_low = 1'b0;

  assign sram_read_valid = ~srv_low;

  initial forever #5 clk = ~clk;

  sram_row_ctrl #(.ROW_LEN(ROW_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .n_rst(n_rst),
    .sd_valid(sd_valid), .sd_data(sd_data), .sd_ack(sd_ack),
    .row_full(row_full), .row_release(row_release),
    .rd_req(rd_req), .rd_row(rd_row), .rd_idx(rd_idx),
    .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_ack(wb_ack),
    .sram_address(sram_address), .sram_mode(sram_mode),
    .sram_addr_calc_mode(sram_addr_calc_mode), .sram_enable(sram_enable),
    .sram_sd_data(sram_sd_data), .sram_wb_data(sram_wb_data),
    .sram_out_data(sram_out_data), .sram_read_valid(sram_read_valid),
    .err(err)
  );

  // Scoreboard state
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int req_cyc = 0;
  int en_cnt = 0, sd_ack_cnt = 0, wb_ack_cnt = 0, rd_ack_cnt = 0, rv_cnt = 0;

  logic [31:0] sd_q[$];
  logic [31:0] wb_q[$];
  logic [13:0] rd_q[$];      // {row, idx}
  logic [59:0] exp_op[$];    // {mode, calc, addr, data}
  logic [31:0] exp_rd[$];
  logic [31:0] mem [logic [25:0]];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [59:0] op_w(input logic calc, input logic [25:0] a, input logic [31:0] d);
    return {1'b0, calc, a, d};
  endfunction

  function automatic logic [59:0] op_r(input logic [25:0] a);
    return {1'b1, 1'b0, a, 32'd0};
  endfunction

  function automatic int pending();
    return sd_q.size() + wb_q.size() + rd_q.size() + exp_op.size() + exp_rd.size();
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM model: operation sampled mid-cycle, applied just after the edge.
  initial begin
    logic        en, md, cm;
    logic [25:0] a;
    logic [31:0] sd, wd;
    sram_out_data = '0;
    forever begin
      @(negedge clk);
      en = sram_enable; md = sram_mode; cm = sram_addr_calc_mode;
      a = sram_address; sd = sram_sd_data; wd = sram_wb_data;
      @(posedge clk);
      #1;
      if (en) begin
        if (!md) mem[a] = cm ? sd : wd;
        else sram_out_data = mem.exists(a) ? mem[a] : 32'd0;
      end
    end
  end

  // Request sources: advance past a word once its ack has been seen.
  initial begin
    sd_valid = 1'b0; sd_data = '0;
    forever begin
      @(negedge clk);
      if (sd_ack && sd_q.size() > 0) void'(sd_q.pop_front());
      sd_valid = sd_q.size() > 0;
      if (sd_valid) sd_data = sd_q[0];
    end
  end

  initial begin
    wb_valid = 1'b0; wb_data = '0;
    forever begin
      @(negedge clk);
      if (wb_ack && wb_q.size() > 0) void'(wb_q.pop_front());
      wb_valid = wb_q.size() > 0;
      if (wb_valid) wb_data = wb_q[0];
    end
  end

  initial begin
    logic popped;
    rd_req = 1'b0; rd_row = 1'b0; rd_idx = '0;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      if (rd_ack && rd_q.size() > 0) begin
        void'(rd_q.pop_front());
        popped = 1'b1;
      end
      if (rd_q.size() > 0 && (!rd_req || popped)) req_cyc = cyc;
      rd_req = rd_q.size() > 0;
      if (rd_req) {rd_row, rd_idx} = rd_q[0];
    end
  end

  // Monitor
  initial forever begin
    logic [59:0] got, want;
    @(negedge clk);
    if (n_rst) begin
      if (sram_enable) en_cnt++;
      if (sd_ack) sd_ack_cnt++;
      if (wb_ack) wb_ack_cnt++;
      if (rd_ack) rd_ack_cnt++;
      if (rd_valid) rv_cnt++;
      if (sram_enable) begin
        got = sram_mode ? op_r(sram_address)
                        : op_w(sram_addr_calc_mode, sram_address,
                               sram_addr_calc_mode ? sram_sd_data : sram_wb_data);
        check("op_expected", 64'(exp_op.size() > 0), 64'd1);
        if (exp_op.size() > 0) begin
          want = exp_op.pop_front();
          check("sram_op", 64'(got), 64'(want));
        end
      end
      if (rd_valid) begin
        check("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
        if (exp_rd.size() > 0) check("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
        check("rd_latency", 64'(cyc - req_cyc), 64'd3);
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    row_release = 2'b00;

    // Reset values and a quiet idle period.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({sram_enable, sram_mode, sram_addr_calc_mode, sd_ack,
                             rd_ack, wb_ack, rd_valid, err, row_full}), 64'd0);
    check("reset_addr", 64'(sram_address), 64'd0);
    check("reset_data", {rd_data, sram_sd_data}, 64'd0);
    check("reset_wb_data", 64'(sram_wb_data), 64'd0);
    n_rst = 1'b1;
    en_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_enable_cycles", 64'(en_cnt), 64'd0);
    check("idle_outputs", 64'({sd_ack, rd_ack, wb_ack, rd_valid, err, row_full}), 64'd0);

    // Fill row 0, then read index 2 back.
    for (int i = 0; i < 4; i++) begin
      sd_q.push_back(32'hA0 + 32'(i));
      exp_op.push_back(op_w(1'b1, 26'(i), 32'hA0 + 32'(i)));
    end
    wait_drain(100);
    check("row_full_row0", 64'(row_full), 64'd1);
    rd_q.push_back({1'b0, 13'd2});
    exp_op.push_back(op_r(26'd2));
    exp_rd.push_back(32'hA2);
    wait_drain(50);

    // Continuous fill until both rows are full, then release row 0.
    do_reset();
    for (int i = 0; i < 9; i++) sd_q.push_back(32'hB0 + 32'(i));
    for (int i = 0; i < 4; i++) exp_op.push_back(op_w(1'b1, 26'(i), 32'hB0 + 32'(i)));
    for (int i = 0; i < 4; i++) exp_op.push_back(op_w(1'b1, 26'd4096 + 26'(i), 32'hB4 + 32'(i)));
    n = 0;
    while (exp_op.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("fill_ops_done", 64'(exp_op.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    sd_ack_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    check("stall_sd_ack", 64'(sd_ack_cnt), 64'd0);
    check("both_full", 64'(row_full), 64'd3);
    check("stall_pending", 64'(sd_q.size()), 64'd1);
    exp_op.push_back(op_w(1'b1, 26'd0, 32'hB8));
    row_release = 2'b01;
    @(posedge clk);
    #1 row_release = 2'b00;
    wait_drain(50);
    check("row_full_after_release", 64'(row_full), 64'd2);

    // Simultaneous requests: read, then WB write, then SD write.
    sd_ack_cnt = 0; wb_ack_cnt = 0; rd_ack_cnt = 0;
    rd_q.push_back({1'b1, 13'd3});
    wb_q.push_back(32'hC0);
    sd_q.push_back(32'hD0);
    exp_op.push_back(op_r(26'd4099));
    exp_op.push_back(op_w(1'b0, 26'd8192, 32'hC0));
    exp_op.push_back(op_w(1'b1, 26'd1, 32'hD0));
    exp_rd.push_back(32'hB7);
    wait_drain(100);
    check("rd_ack_pulses", 64'(rd_ack_cnt), 64'd1);
    check("wb_ack_pulses", 64'(wb_ack_cnt), 64'd1);
    check("sd_ack_pulses", 64'(sd_ack_cnt), 64'd1);

    // Output index wraps after OUT_LEN words.
    do_reset();
    for (int i = 0; i < 4; i++) wb_q.push_back(32'hE0 + 32'(i));
    exp_op.push_back(op_w(1'b0, 26'd8192, 32'hE0));
    exp_op.push_back(op_w(1'b0, 26'd8193, 32'hE1));
    exp_op.push_back(op_w(1'b0, 26'd8194, 32'hE2));
    exp_op.push_back(op_w(1'b0, 26'd8192, 32'hE3));
    wait_drain(100);

    // Invalid read return sets sticky err; rd_valid still pulses.
    srv_low = 1'b1;
    rd_q.push_back({1'b0, 13'd0});
    exp_op.push_back(op_r(26'd0));
    exp_rd.push_back(32'hB8);
    wait_drain(50);
    srv_low = 1'b0;
    check("err_set", 64'(err), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 64'(err), 64'd1);

    // Reset while a read is in READ: no rd_valid must follow.
    rd_q.push_back({1'b0, 13'd1});
    exp_op.push_back(op_r(26'd1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_ack && n < 20);
    check("rd_ack_seen", 64'(rd_ack), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    check("enable_async_drop", 64'(sram_enable), 64'd0);
    check("err_cleared", 64'(err), 64'd0);
    rv_cnt = 0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("no_rd_valid_after_reset", 64'(rv_cnt), 64'd0);
    check("final_pending", 64'(pending()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sram_row_ctrl.md
# sram_row_ctrl

Initiator-side controller for the frame SRAM: it sequences every read and write the chip makes to the SRAM model, and drives its address, mode, addrCalcMode and enable lines. It ping-pong fills two row-cache regions from the SDRAM buffer. It serves indexed row-cache reads to the window buffer and streams window-buffer results into the output array region. All SRAM-facing outputs are registered, and requests are arbitrated one operation at a time.

## Interface
- ROW_LEN, 640: words per cached row; fill index wraps at ROW_LEN.
- OUT_LEN, 307200: words in the output array; output index wraps at OUT_LEN.
- ROW0_BASE, 26'd0: SRAM base address of row cache 0.
- ROW1_BASE, 26'd4096: SRAM base address of row cache 1.
- OUT_BASE, 26'd8192: SRAM base address of the output array.
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- sd_valid  in  1  SDRAM buffer has a word on sd_data.
- sd_data  in  32  SDRAM word to cache.
- sd_ack  out  1  one-cycle pulse: sd_data captured.
- row_full  out  2  bit r set when row r is completely filled.
- row_release  in  2  one-cycle pulse on bit r clears row_full[r].
- rd_req  in  1  window buffer read request.
- rd_row  in  1  row cache to read.
- rd_idx  in  13  word index within row.
- rd_ack  out  1  one-cycle pulse: read request accepted.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  32  read result, held until next read.
- wb_valid  in  1  window buffer result available.
- wb_data  in  32  result word.
- wb_ack  out  1  one-cycle pulse: wb_data captured.
- sram_address  out  26  to SRAM address.
- sram_mode  out  1  1 = read, 0 = write.
- sram_addr_calc_mode  out  1  1 = write sdram_data, 0 = write wb_data.
- sram_enable  out  1  SRAM operation strobe.
- sram_sd_data  out  32  to SRAM sdram_data.
- sram_wb_data  out  32  to SRAM wb_data.
- sram_out_data  in  32  from SRAM out_data.
- sram_read_valid  in  1  from SRAM dataReadValid.
- err  out  1  sticky: sram_read_valid low in CAPTURE.

## Operation
- States: IDLE, READ, CAPTURE, WRITE.
- IDLE arbitration, fixed priority: rd_req, then wb_valid, then sd_valid. sd_valid is eligible only when row_full[fill_row] = 0.
- Read accepted:
  - Go to READ and register sram_enable=1, sram_mode=1.
  - sram_address = (rd_row ? ROW1_BASE : ROW0_BASE) + rd_idx, truncated to 26 bits.
  - rd_ack pulses.
  - rd_idx ≥ ROW_LEN is not checked; it is issued as computed.
- READ goes to CAPTURE with sram_enable=0.
- CAPTURE goes to IDLE with rd_data ← sram_out_data and rd_valid=1. If sram_read_valid=0 in CAPTURE, err is set and held until reset; rd_valid still pulses.
- sram_read_valid is never used outside CAPTURE. The SRAM holds it high across write cycles.
- WB write accepted:
  - Go to WRITE with sram_enable=1, sram_mode=0, sram_addr_calc_mode=0.
  - sram_wb_data ← wb_data; address = OUT_BASE + out_cnt; wb_ack pulses.
  - out_cnt increments and wraps OUT_LEN-1 → 0.
- SD write accepted:
  - Same as WB write, but sram_addr_calc_mode=1 and sram_sd_data ← sd_data.
  - Address = fill row base + fill_cnt; sd_ack pulses.
  - When fill_cnt = ROW_LEN-1: fill_cnt ← 0, row_full[fill_row] ← 1, fill_row toggles. Otherwise fill_cnt increments.
- WRITE returns to IDLE with sram_enable=0.
- row_release[r] clears row_full[r] on the next edge, in any state. If a set and a release of the same bit land on the same edge, the set wins.
- Both rows full: the fill stalls (no sd_ack) until a release arrives.
- Requesters drop or advance their request on the edge that ends their ack cycle. A request still asserted in the cycle after its ack is treated as a new request.

## Timing
- Reset values:
  - All outputs 0, including rd_data and err.
  - State IDLE; fill_cnt, out_cnt and fill_row all 0.
- Read: rd_req sampled at edge E1 (state IDLE).
  - Cycle after E1: rd_ack=1, SRAM read driven.
  - SRAM captures at E2, and sram_out_data is valid in the cycle after E2.
  - rd_valid=1 in the cycle after E3. Request-to-rd_valid latency is 3 cycles.
- Write: request sampled at E1. The ack and the SRAM write strobe are both high in the cycle after E1. The SRAM writes at E2, and the controller returns to IDLE at E2.
- Throughput: one write per 2 cycles; one read per 3 cycles.
- Reset mid-operation:
  - sram_enable drops asynchronously.
  - An in-flight read produces no rd_valid.
  - An in-flight write may or may not have reached the SRAM.

## Test plan
- Reset then idle, no requests: all outputs 0 and sram_enable stays 0 for 20 cycles.
- Fill row 0 with ROW_LEN=4 (data 0xA0..0xA3), then read rd_row=0, rd_idx=2: writes go to addresses 0..3; row_full=01; rd_data=0xA2 with rd_valid exactly 3 cycles after rd_req.
- Continuous sd_valid with ROW_LEN=4 and no releases:
  - 8 writes land at 0..3 and 4096..4099; row_full=11; sd_ack stays 0.
  - After row_release=01, the next word is written at address 0.
- Simultaneous rd_req, wb_valid and sd_valid in one cycle: service order is read, then WB write (address OUT_BASE), then SD write; each ack pulses exactly once.
- OUT_LEN=3 with 4 WB writes: addresses 8192, 8193, 8194, 8192.
- Hold sram_read_valid at 0 during CAPTURE: err=1 and stays 1; assert n_rst mid-READ and check no rd_valid follows.
